uart_rx_only: RTL and testbench



---
 rtl/uart_rx_only.sv | 133 +++++++++++++
 tb/tb_uart_rx_only.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_only.sv
// 8N1 UART receiver with mid-bit sampling on the system clock.
// Bytes are held on a level-valid/acknowledge interface with framing-error and overrun pulses.
module uart_rx_only #(
   parameter int unsigned CLKS_PER_BIT = 87,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk10mhz,
   input  logic       rst,
   input  logic       uRx,
   output logic [7:0] rxData8,
   output logic       rxValid,
   input  logic       rxAck,
   output logic       rxBusy,
   output logic       rxFrameErr,
   output logic       rxOverrun
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StStart = 3'd1;
   localparam logic [2:0] StData  = 3'd2;
   localparam logic [2:0] StStop  = 3'd3;
   localparam logic [2:0] StBreak = 3'd4;

   localparam logic [15:0] HalfLast = 16'(HALF_BIT - 1);
   localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);

   logic        rxMeta;
   logic        rxS;
   logic [2:0]  stateQ;
   logic [2:0]  stateD;
   logic [15:0] clkCntQ;
   logic [15:0] clkCntD;
   logic [2:0]  bitIdxQ;
   logic [2:0]  bitIdxD;
   logic [7:0]  shiftQ;
   logic [7:0]  shiftD;
   logic        loadPendQ;
   logic        loadD;
   logic        frameErrD;

   always_comb begin
      stateD    = stateQ;
      clkCntD   = clkCntQ + 16'd1;
      bitIdxD   = bitIdxQ;
      shiftD    = shiftQ;
      loadD     = 1'b0;
      frameErrD = 1'b0;
      case (stateQ)
         StIdle: begin
            // The cycle that first sees the start bit counts as clock 0 of the half bit.
            if (!rxS) begin
               stateD  = StStart;
               clkCntD = 16'd1;
            end else begin
               clkCntD = 16'd0;
            end
         end
         StStart: begin
            if (clkCntQ == HalfLast) begin
               clkCntD = 16'd0;
               bitIdxD = 3'd0;
               stateD  = rxS ? StIdle : StData;
            end
         end
         StData: begin
            if (clkCntQ == BitLast) begin
               clkCntD         = 16'd0;
               shiftD[bitIdxQ] = rxS;
               bitIdxD         = bitIdxQ + 3'd1;
               if (bitIdxQ == 3'd7) begin
                  stateD = StStop;
               end
            end
         end
         StStop: begin
            // Leave mid-stop-bit so a back-to-back start edge is not missed.
            if (clkCntQ == BitLast) begin
               clkCntD   = 16'd0;
               stateD    = rxS ? StIdle : StBreak;
               loadD     = rxS;
               frameErrD = !rxS;
            end
         end
         StBreak: begin
            clkCntD = 16'd0;
            if (rxS) begin
               stateD = StIdle;
            end
         end
         default: begin
            stateD  = StIdle;
            clkCntD = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk10mhz) begin
      if (rst) begin
         rxMeta     <= 1'b1;
         rxS        <= 1'b1;
         stateQ     <= StIdle;
         clkCntQ    <= 16'd0;
         bitIdxQ    <= 3'd0;
         shiftQ     <= 8'h00;
         loadPendQ  <= 1'b0;
         rxData8    <= 8'h00;
         rxValid    <= 1'b0;
         rxBusy     <= 1'b0;
         rxFrameErr <= 1'b0;
         rxOverrun  <= 1'b0;
      end else begin
         rxMeta     <= uRx;
         rxS        <= rxMeta;
         stateQ     <= stateD;
         clkCntQ    <= clkCntD;
         bitIdxQ    <= bitIdxD;
         shiftQ     <= shiftD;
         loadPendQ  <= loadD;
         rxBusy     <= (stateD != StIdle);
         rxFrameErr <= frameErrD;
         rxOverrun  <= 1'b0;
         // A load on the same cycle as rxAck wins and is not an overrun.
         if (loadPendQ) begin
            rxData8   <= shiftQ;
            rxValid   <= 1'b1;
            rxOverrun <= rxValid && !rxAck;
         end else if (rxAck) begin
            rxValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_only.sv
// Bench for uart_rx_only: frame-level reference model (expected load/error cycles and busy
// windows computed from line timing) compared every cycle, plus directed literal checks.
module tb_uart_rx_only;

   localparam int C = 87;
   localparam int H = C / 2;

   logic       clk10mhz = 1'b0;
   logic       rst;
   logic       uRx;
   logic       rxAck;
   logic [7:0] rxData8;
   logic       rxValid;
   logic       rxBusy;
   logic       rxFrameErr;
   logic       rxOverrun;

   uart_rx_only #(.CLKS_PER_BIT(C)) dut (
      .clk10mhz  (clk10mhz),
      .rst       (rst),
      .uRx       (uRx),
      .rxData8   (rxData8),
      .rxValid   (rxValid),
      .rxAck     (rxAck),
      .rxBusy    (rxBusy),
      .rxFrameErr(rxFrameErr),
      .rxOverrun (rxOverrun)
   );

   always #50 clk10mhz = ~clk10mhz;

   typedef struct {
      int         cyc;
      bit         err;
      logic [7:0] data;
   } evT;

   evT         evQ[$];
   int         cyc     = -1;
   int         checks  = 0;
   int         errors  = 0;
   int         busyLo  = 0;
   int         busyHi  = 0;
   int         ovrCnt  = 0;
   int         ferrCnt = 0;
   logic       expValid;
   logic [7:0] expData;
   logic       eFerr;
   logic       eOvr;
   logic       eBusy;
   evT         curEv;
   int         t0;
   logic [7:0] tolB[4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
   int         tolP[4] = '{85, 89, 89, 85};
   logic [7:0] rb;
   int         rbp;
   int         rhold;
   int         rgap;
   logic       rstop;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
      end
   endtask

   // Reference model: applies scheduled frame outcomes and acks, then compares every cycle.
   initial begin
      expValid = 1'b0;
      expData  = 8'h00;
      forever begin
         @(posedge clk10mhz);
         cyc++;
         #1;
         eFerr = 1'b0;
         eOvr  = 1'b0;
         if (rst) begin
            expValid = 1'b0;
            expData  = 8'h00;
            evQ.delete();
            busyLo = 0;
            busyHi = 0;
         end else if (evQ.size() > 0 && evQ[0].cyc == cyc) begin
            curEv = evQ.pop_front();
            if (curEv.err) begin
               eFerr = 1'b1;
            end else begin
               eOvr     = expValid && !rxAck;
               expValid = 1'b1;
               expData  = curEv.data;
            end
         end else if (rxAck) begin
            expValid = 1'b0;
         end
         eBusy = (cyc >= busyLo) && (cyc < busyHi);
         if (rxFrameErr === 1'b1) ferrCnt++;
         if (rxOverrun === 1'b1) ovrCnt++;
         check("rxValid", 32'(rxValid), 32'(expValid));
         check("rxData8", 32'(rxData8), 32'(expData));
         check("rxBusy", 32'(rxBusy), 32'(eBusy));
         check("rxFrameErr", 32'(rxFrameErr), 32'(eFerr));
         check("rxOverrun", 32'(rxOverrun), 32'(eOvr));
      end
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic waitCyc(input int c);
      while (cyc < c) @(negedge clk10mhz);
   endtask

   task automatic pulseAck();
      rxAck = 1'b1;
      @(negedge clk10mhz);
      rxAck = 1'b0;
   endtask

   // Start bit first sampled at edge t0; good byte loads at t0+H+9C+2, stop sample at t0+H+9C+1.
   task automatic sendFrame(input logic [7:0] b, input int bp, input logic stopBit,
                            input int holdBits, input int gap);
      int tf;
      evT e;
      tf = cyc + 1;
      if (stopBit) begin
         e.cyc  = tf + H + 9 * C + 2;
         e.err  = 1'b0;
         e.data = b;
         busyHi = tf + H + 9 * C + 1;
      end else begin
         e.cyc  = tf + H + 9 * C + 1;
         e.err  = 1'b1;
         e.data = 8'h00;
         busyHi = tf + (10 + holdBits) * bp + 2;
      end
      busyLo = tf + 2;
      evQ.push_back(e);
      uRx = 1'b0;
      repeat (bp) @(negedge clk10mhz);
      for (int i = 0; i < 8; i++) begin
         uRx = b[i];
         repeat (bp) @(negedge clk10mhz);
      end
      uRx = stopBit;
      repeat (bp * (stopBit ? 1 : 1 + holdBits)) @(negedge clk10mhz);
      uRx = 1'b1;
      repeat (gap) @(negedge clk10mhz);
   endtask

   initial begin
      rst   = 1'b1;
      uRx   = 1'b1;
      rxAck = 1'b0;
      repeat (5) @(negedge clk10mhz);
      rst = 1'b0;
      repeat (10) @(negedge clk10mhz);
      check("resetData", 32'(rxData8), 32'h00);
      check("resetValid", 32'(rxValid), 32'h0);
      check("resetBusy", 32'(rxBusy), 32'h0);

      // 0x55: valid rises 87*9+43+2 = 828 clocks after the first sampling edge.
      t0 = cyc + 1;
      fork
         sendFrame(8'h55, C, 1'b1, 0, 50);
         begin
            waitCyc(t0 + 827);
            check("validBefore828", 32'(rxValid), 32'h0);
            waitCyc(t0 + 828);
            check("validAt828", 32'(rxValid), 32'h1);
            check("data55", 32'(rxData8), 32'h55);
            pulseAck();
            check("ackClears", 32'(rxValid), 32'h0);
         end
      join

      // 20-clock low glitch aborts at mid-start sample.
      ferrCnt = 0;
      t0      = cyc + 1;
      busyLo  = t0 + 2;
      busyHi  = t0 + H + 1;
      uRx     = 1'b0;
      repeat (20) @(negedge clk10mhz);
      uRx = 1'b1;
      repeat (100) @(negedge clk10mhz);
      check("glitchBusy", 32'(rxBusy), 32'h0);
      check("glitchValid", 32'(rxValid), 32'h0);
      check("glitchData", 32'(rxData8), 32'h55);
      check("glitchFerr", 32'(ferrCnt), 32'd0);

      // 0xA3 with low stop bit, held low 3 more bit times.
      ferrCnt = 0;
      t0      = cyc + 1;
      fork
         sendFrame(8'hA3, C, 1'b0, 3, 100);
         begin
            waitCyc(t0 + 13 * C + 1);
            check("breakBusyHeld", 32'(rxBusy), 32'h1);
            waitCyc(t0 + 13 * C + 2);
            check("breakBusyFalls", 32'(rxBusy), 32'h0);
         end
      join
      check("breakOneFerr", 32'(ferrCnt), 32'd1);
      check("breakValid", 32'(rxValid), 32'h0);
      check("breakData", 32'(rxData8), 32'h55);

      // Back-to-back without ack: one overrun.
      ovrCnt = 0;
      sendFrame(8'h12, C, 1'b1, 0, 0);
      sendFrame(8'h34, C, 1'b1, 0, 100);
      check("b2bOverrun", 32'(ovrCnt), 32'd1);
      check("b2bData", 32'(rxData8), 32'h34);
      check("b2bValid", 32'(rxValid), 32'h1);
      pulseAck();

      // Back-to-back with ack on the exact load cycle of the second byte.
      ovrCnt = 0;
      sendFrame(8'h12, C, 1'b1, 0, 0);
      t0 = cyc + 1;
      fork
         sendFrame(8'h34, C, 1'b1, 0, 100);
         begin
            waitCyc(t0 + 827);
            pulseAck();
         end
      join
      check("ackLoadNoOverrun", 32'(ovrCnt), 32'd0);
      check("ackLoadValid", 32'(rxValid), 32'h1);
      check("ackLoadData", 32'(rxData8), 32'h34);

      // Reset in the middle of bit 4 of 0xFF, then 0x0F.
      ferrCnt = 0;
      ovrCnt  = 0;
      t0      = cyc + 1;
      busyLo  = t0 + 2;
      busyHi  = t0 + H + 9 * C + 1;
      uRx     = 1'b0;
      repeat (C) @(negedge clk10mhz);
      uRx = 1'b1;
      repeat (4 * C + C / 2) @(negedge clk10mhz);
      rst = 1'b1;
      @(negedge clk10mhz);
      check("rstData", 32'(rxData8), 32'h00);
      check("rstValid", 32'(rxValid), 32'h0);
      check("rstBusy", 32'(rxBusy), 32'h0);
      rst = 1'b0;
      repeat (5 * C) @(negedge clk10mhz);
      sendFrame(8'h0F, C, 1'b1, 0, 50);
      check("afterRstData", 32'(rxData8), 32'h0F);
      check("afterRstValid", 32'(rxValid), 32'h1);
      check("rstNoFerr", 32'(ferrCnt), 32'd0);
      check("rstNoOverrun", 32'(ovrCnt), 32'd0);
      pulseAck();

      // Baud tolerance at about +-2%.
      ferrCnt = 0;
      for (int i = 0; i < 4; i++) begin
         sendFrame(tolB[i], tolP[i], 1'b1, 0, 60);
         check("tolData", 32'(rxData8), 32'(tolB[i]));
         pulseAck();
      end
      check("tolNoFerr", 32'(ferrCnt), 32'd0);

      // Random frames, bit periods, framing errors, gaps and acks.
      for (int n = 0; n < 25; n++) begin
         rb    = 8'($urandom);
         rbp   = $urandom_range(85, 89);
         rstop = ($urandom_range(0, 5) != 0);
         rhold = $urandom_range(0, 3);
         rgap  = $urandom_range(4, 120);
         fork
            sendFrame(rb, rbp, rstop, rhold, rgap);
            begin
               for (int i = 0; i < 800; i++) begin
                  rxAck = ($urandom_range(0, 99) < 3);
                  @(negedge clk10mhz);
               end
               rxAck = 1'b0;
            end
         join
      end

      repeat (20) @(negedge clk10mhz);
      check("eventsDrained", 32'(evQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
